travel_plan_seq: RTL



---
 rtl/travel_plan_pkg.sv | 25 ++
 rtl/travel_plan_seq_gap_det.sv | 39 +++
 rtl/travel_plan_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/travel_plan_pkg.sv
// Shared types for the travel-plan sequencer.
//   turn_t  : 2-bit turn code carried in the plan word and on the turn output
//   state_t : sequencer states
//   PLAN_CODES / PLAN_W : number of codes per plan word and its bit width
package travel_plan_pkg;

  localparam int PLAN_CODES = 8;
  localparam int PLAN_W     = 2 * PLAN_CODES;

  typedef enum logic [1:0] {
    STRAIGHT = 2'b00,
    RIGHT    = 2'b01,
    LEFT     = 2'b10,
    END      = 2'b11
  } turn_t;

  typedef enum logic [2:0] {
    IDLE,
    FOLLOW,
    TURN,
    DONE,
    BUMP
  } state_t;

endpackage

// File: rtl/travel_plan_seq_gap_det.sv
// gap_det: counts consecutive clk cycles with line_present=0 while enabled.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous counter clear (wins over en)
//   en            : counting enable (sequencer following the line)
//   line_present  : line sensed under IR array
//   gap           : one-cycle pulse on the GAP_CYC-th consecutive low cycle
module gap_det #(
  parameter int GAP_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic line_present,
  output logic gap
);

  localparam int            CW      = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(GAP_CYC);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (line_present)        cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;  // saturate: one pulse per gap
    end
  end

  // The cycle that would take the count to GAP_CYC is the qualifying cycle.
  assign gap = en && !line_present && (cnt == CNT_MAX - 1'b1);

endmodule

// File: rtl/travel_plan_seq.sv
// travel_plan_seq: turns a 16-bit UART travel plan into per-gap turn commands.
//   clk, rst      : clock, asynchronous active-high reset
//   cmd, cmd_rdy  : plan word (eight 2-bit codes, [1:0] first) and its valid level
//   clr_cmd_rdy   : one-cycle acknowledge of plan capture
//   line_present  : line sensed under IR array
//   BMPL_n/BMPR_n : asynchronous active-low bump switches
//   go            : drive enable to motor/PID stage
//   turn/turn_vld : current turn code and one-cycle update pulse
//   plan_done     : plan exhausted, runner stopped
//   buzz_en       : piezo enable after a bump
module travel_plan_seq
  import travel_plan_pkg::*;
#(
  parameter int GAP_CYC  = 4096,
  parameter int TURN_CYC = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PLAN_W-1:0] cmd,
  input  logic              cmd_rdy,
  output logic              clr_cmd_rdy,
  input  logic              line_present,
  input  logic              BMPL_n,
  input  logic              BMPR_n,
  output logic              go,
  output logic [1:0]        turn,
  output logic              turn_vld,
  output logic              plan_done,
  output logic              buzz_en
);

  localparam int            HW       = $clog2(TURN_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(TURN_CYC - 1);

  state_t            state, state_nxt;
  logic [PLAN_W-1:0] plan_reg;
  turn_t             turn_r;
  turn_t             code;
  logic [HW-1:0]     hold_cnt;
  logic              hold_sat;
  logic [1:0]        bmpl_sync, bmpr_sync;
  logic              bump;
  logic              gap;
  logic              capture, take_turn, turn_exit;

  // Two-flop synchronizers; idle-high so reset does not look like a bump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bmpl_sync <= 2'b11;
      bmpr_sync <= 2'b11;
    end else begin
      bmpl_sync <= {bmpl_sync[0], BMPL_n};
      bmpr_sync <= {bmpr_sync[0], BMPR_n};
    end
  end

  assign bump     = !bmpl_sync[1] || !bmpr_sync[1];
  assign code     = turn_t'(plan_reg[1:0]);
  assign hold_sat = (hold_cnt == HOLD_MAX);

  gap_det #(.GAP_CYC(GAP_CYC)) u_gap_det (
    .clk          (clk),
    .rst          (rst),
    .clr          (capture || turn_exit),
    .en           (state == FOLLOW),
    .line_present (line_present),
    .gap          (gap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    take_turn = 1'b0;
    turn_exit = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_rdy) begin
          capture   = 1'b1;
          state_nxt = FOLLOW;
        end
      end
      FOLLOW: begin
        // Bump beats a coincident gap, so the plan is not shifted.
        if (bump) begin
          state_nxt = BUMP;
        end else if (gap) begin
          if (code == END) begin
            state_nxt = DONE;
          end else begin
            take_turn = 1'b1;
            state_nxt = TURN;
          end
        end
      end
      TURN: begin
        if (bump) begin
          state_nxt = BUMP;
        end else if (hold_sat && line_present) begin
          turn_exit = 1'b1;
          state_nxt = FOLLOW;
        end
      end
      DONE: begin
        if (bump) begin
          state_nxt = BUMP;
        end else if (cmd_rdy) begin
          capture   = 1'b1;
          state_nxt = FOLLOW;
        end
      end
      BUMP: begin
        // A reload only counts once the bumper has been released.
        if (cmd_rdy && !bump) begin
          capture   = 1'b1;
          state_nxt = FOLLOW;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plan_reg <= '1;
      turn_r   <= STRAIGHT;
      turn_vld <= 1'b0;
      hold_cnt <= '0;
    end else begin
      turn_vld <= take_turn;

      if (capture)        plan_reg <= cmd;
      else if (take_turn) plan_reg <= {END, plan_reg[PLAN_W-1:2]};  // refill with end-of-plan

      if (take_turn)
        turn_r <= code;
      else if (turn_exit || state_nxt == DONE || state_nxt == BUMP)
        turn_r <= STRAIGHT;

      if (take_turn)                        hold_cnt <= '0;
      else if (state == TURN && !hold_sat)  hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign turn        = turn_r;
  assign clr_cmd_rdy = capture;
  assign go          = (state == FOLLOW) || (state == TURN);
  assign plan_done   = (state == DONE);
  assign buzz_en     = (state == BUMP);

endmodule
